// File: rtl/pixel_cmd_pkg.sv
// pixel_cmd_pkg: command word layout, op codes, status layout and engine states for pixel_cmd_engine.
package pixel_cmd_pkg;
  localparam logic [1:0] OP_PLOT    = 2'b00;
  localparam logic [1:0] OP_CLEAR   = 2'b01;
  localparam logic [1:0] OP_CLR_ERR = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;
  localparam int TOGGLE_BIT = 31;
  localparam int OP_MSB     = 30;
  localparam int OP_LSB     = 29;
  localparam int Y_MSB      = 28;
  localparam int Y_LSB      = 19;
  localparam int X_MSB      = 18;
  localparam int X_LSB      = 9;
  localparam int COLOR_MSB  = 7;
  localparam int COLOR_LSB  = 0;
  localparam int ST_ACK     = 31;
  localparam int ST_BUSY    = 30;
  localparam int ST_ERR     = 29;
  localparam int ST_CNT_MSB = 28;
  typedef enum logic [2:0] {IDLE, DECODE, WRITE, FILL, ACK} state_e;
endpackage

// File: rtl/pixel_addr_calc.sv
// pixel_addr_calc: registered framebuffer address (FB_BASE + y*H_RES + x) and range check.
module pixel_addr_calc #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int FB_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              out_of_range_o
);
  logic [ADDR_W-1:0] addr_q;
  logic              oor_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      oor_q  <= 1'b0;
    end else if (load_i) begin
      addr_q <= ADDR_W'(FB_BASE) + ADDR_W'(y_i) * ADDR_W'(H_RES) + ADDR_W'(x_i);
      oor_q  <= ({22'd0, x_i} >= 32'(H_RES)) || ({22'd0, y_i} >= 32'(V_RES));
    end
  end
  assign addr_o         = addr_q;
  assign out_of_range_o = oor_q;
endmodule

// File: rtl/pixel_cmd_engine.sv
// pixel_cmd_engine: toggle-handshaked pixel command decoder driving Avalon-MM framebuffer writes.
// Optional PIXEL_STATS_EN: status_out[28:0] counts accepted writes (saturating), else tied to 0.
module pixel_cmd_engine
  import pixel_cmd_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int FB_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cmd_in,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [7:0]        avm_writedata,
  input  logic              avm_waitrequest,
  output logic [31:0]       status_out
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
  state_e            state_q, state_d;
  logic [1:0]        op_q;
  logic [7:0]        color_q;
  logic              ack_q, ack_d, err_q, err_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, calc_addr;
  logic              oor, pending, load, accept;
  logic [28:0]       pix_cnt;
  logic              unused_rsvd;
  assign unused_rsvd = cmd_in[8];
  assign pending = cmd_in[TOGGLE_BIT] != ack_q;
  assign load    = (state_q == IDLE) && pending;
  assign accept  = avm_write && !avm_waitrequest;
  pixel_addr_calc #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .FB_BASE(FB_BASE)) u_calc (
    .clk(clk), .reset(reset), .load_i(load),
    .x_i(cmd_in[X_MSB:X_LSB]), .y_i(cmd_in[Y_MSB:Y_LSB]),
    .addr_o(calc_addr), .out_of_range_o(oor)
  );
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   state_d = pending ? DECODE : IDLE;
      DECODE: begin
        state_d = ACK;
        if (op_q == OP_PLOT) begin
          state_d = oor ? ACK : WRITE;
          err_d   = err_q | oor;
        end else if (op_q == OP_CLEAR) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (op_q == OP_CLR_ERR) begin
          err_d = 1'b0;
        end
      end
      WRITE:  state_d = avm_waitrequest ? WRITE : ACK;
      FILL:   begin
        // Counter holds at the last pixel so it can never wrap.
        state_d = (!avm_waitrequest && cnt_q == LAST) ? ACK : FILL;
        cnt_d   = (!avm_waitrequest && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
      end
      ACK:    begin
        ack_d   = ~ack_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_PLOT;
      color_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q    <= cmd_in[OP_MSB:OP_LSB];
        color_q <= cmd_in[COLOR_MSB:COLOR_LSB];
      end
    end
  end
  assign avm_write     = (state_q == WRITE) || (state_q == FILL);
  assign avm_address   = (state_q == FILL) ? ADDR_W'(FB_BASE) + cnt_q : (state_q == WRITE) ? calc_addr : '0;
  assign avm_writedata = avm_write ? color_q : '0;
`ifdef PIXEL_STATS_EN
  logic [28:0] pix_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) pix_cnt_q <= '0;
    else if (accept && !(&pix_cnt_q)) pix_cnt_q <= pix_cnt_q + 1'b1;
  end
  assign pix_cnt = pix_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign pix_cnt = '0;
`endif
  always_comb begin
    status_out                = '0;
    status_out[ST_ACK]        = ack_q;
    status_out[ST_BUSY]       = state_q != IDLE;
    status_out[ST_ERR]        = err_q;
    status_out[ST_CNT_MSB:0]  = pix_cnt;
  end
endmodule

// File: doc/pixel_cmd_engine.md
Name: pixel_cmd_engine

Overview:
Fabric-side consumer of the 32-bit pixel command word driven by the HPS-written set_pixel PIO output port. Detects a new command by a toggle bit, decodes it, and issues Avalon-MM master writes into the framebuffer: one pixel, or a full-screen fill. Completion is returned as an ack toggle plus status bits on a 32-bit word, which feeds an input PIO so software can poll it.

Parameters:
H_RES, 640, horizontal resolution in pixels
V_RES, 480, vertical resolution in pixels
ADDR_W, 19, framebuffer word-address width; must hold FB_BASE + H_RES*V_RES - 1
FB_BASE, 0, framebuffer base word address

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_in  in  32  command word from PIO: [31] req toggle, [30:29] op, [28:19] y, [18:9] x, [8] reserved, [7:0] color
avm_address  out  ADDR_W  framebuffer word address
avm_write  out  1  write request
avm_writedata  out  8  pixel colour
avm_waitrequest  in  1  slave stall
status_out  out  32  [31] ack toggle, [30] busy, [29] sticky range error, [28:0] pixel count (optional feature, else 0)

Behaviour:
- Reset values: avm_write=0, avm_address=0, avm_writedata=0, status_out=0, state=IDLE. Reset mid-operation aborts immediately; avm_write is low the cycle after reset is sampled, and the ack toggle returns to 0.
- Request pending when cmd_in[31] != ack toggle. cmd_in is sampled into a command register only in IDLE. Changes to cmd_in while busy are ignored. A double toggle while busy is lost; software must wait for ack before issuing the next command.
- Op encoding: 00 PLOT, 01 CLEAR (fill all pixels with color), 10 CLR_ERR (clear sticky error), 11 reserved (no-op, still acked).
- States:
  - IDLE: on pending request, latch cmd, go DECODE.
  - DECODE: 1 cycle. PLOT computes addr = FB_BASE + y*H_RES + x, registered, then goes WRITE. If x>=H_RES or y>=V_RES, no write, set error, go ACK. CLEAR loads pixel counter=0, goes FILL. CLR_ERR and reserved clear/no-op, go ACK.
  - WRITE: assert avm_write with address and data stable while avm_waitrequest=1. Exit to ACK on the first cycle where avm_write=1 and avm_waitrequest=0.
  - FILL: avm_address = FB_BASE + counter. Counter advances on each accepted write. After the accepted write at H_RES*V_RES-1, go ACK. avm_write stays high across consecutive accepted writes, one pixel per cycle with no stall.
  - ACK: flip ack toggle, go IDLE. A new request can be accepted the cycle after ACK.
- Busy = (state != IDLE).
- Latency: a PLOT with no wait states has toggle sampled in cycle 0; DECODE in 1; write accepted in 2; ack visible in 4.
- Arithmetic: the y*H_RES product is computed at ADDR_W width. Operands are unsigned. The FILL counter is ADDR_W wide and never wraps past the last pixel.

Optional Feature:
PIXEL_STATS_EN:
- Defined: status_out[28:0] counts accepted framebuffer writes, from PLOT and FILL. It saturates at all-ones, resets to 0 on reset, and is not cleared by CLR_ERR.
- Undefined: status_out[28:0] is tied to 0 and no counter logic exists.

Decomposition:
- Package pixel_cmd_pkg holds:
  - op encodings;
  - cmd field bit positions: TOGGLE_BIT, OP_MSB/LSB, Y_MSB/LSB, X_MSB/LSB, COLOR_MSB/LSB;
  - status bit positions;
  - state enum: IDLE, DECODE, WRITE, FILL, ACK.
- One sub-module, pixel_addr_calc: registered range check plus y*H_RES+x+FB_BASE. Parameters H_RES, V_RES, ADDR_W, FB_BASE; outputs addr and out_of_range.

Test Plan:
- Reset -> all outputs 0; cmd_in=0 causes no request; state stays IDLE for 20 cycles.
- PLOT with x=5, y=2, color=0xA5, toggle 0->1 -> single write at address 1285, data 0xA5; status_out[31]=1 in cycle 4; busy low afterwards.
- Same PLOT with avm_waitrequest held 3 cycles -> address and data stable throughout, exactly one accepted write, ack delayed 3 cycles.
- PLOT with x=640, y=0 -> no avm_write; status bit 29=1; ack toggles. Then CLR_ERR -> bit 29=0, ack toggles again.
- H_RES=4, V_RES=3, CLEAR with color=0x3C, no stalls -> 12 back-to-back writes at addresses 0..11, data 0x3C; with PIXEL_STATS_EN, count=12.
- Reset asserted at the 6th FILL write -> avm_write=0 next cycle, status_out=0. A fresh PLOT afterwards completes normally.
